// File: rtl/nv_nvdla_bdma_mch_load.sv
// nv_nvdla_bdma_mch_load: multi-channel BDMA load engine with round-robin line-request issue.
// Optional macro NVDLA_BDMA_MCH_STALL_CNT_EN adds a saturating request-stall counter.
`default_nettype none

module nv_nvdla_bdma_mch_load #(
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 2,
  parameter int AW       = 64,
  parameter int LINE_W   = 13,
  parameter int REP_W    = 24,
  parameter int STRIDE_W = 27
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CH_W-1:0]     cmd_ch,
  input  logic [AW-1:0]       cmd_src_addr,
  input  logic [LINE_W-1:0]   cmd_line_size,
  input  logic [REP_W-1:0]    cmd_line_repeat,
  input  logic [REP_W-1:0]    cmd_surf_repeat,
  input  logic [STRIDE_W-1:0] cmd_line_stride,
  input  logic [STRIDE_W-1:0] cmd_surf_stride,
  output logic                rd_req_valid,
  input  logic                rd_req_ready,
  output logic [AW-1:0]       rd_req_addr,
  output logic [LINE_W-1:0]   rd_req_size,
  output logic [CH_W-1:0]     rd_req_ch,
  output logic                rd_req_last,
  output logic [NUM_CH-1:0]   ch_busy,
  output logic [NUM_CH-1:0]   ch_done,
`ifdef NVDLA_BDMA_MCH_STALL_CNT_EN
  input  logic                stall_cnt_clr,
  output logic [31:0]         stall_cnt,
`endif
  output logic                idle
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  logic [1:0]          r_state    [NUM_CH];
  logic [AW-1:0]       r_line_ptr [NUM_CH];
  logic [AW-1:0]       r_surf_ptr [NUM_CH];
  logic [LINE_W-1:0]   r_size     [NUM_CH];
  logic [REP_W-1:0]    r_line_rep [NUM_CH];
  logic [REP_W-1:0]    r_surf_rep [NUM_CH];
  logic [REP_W-1:0]    r_line_cnt [NUM_CH];
  logic [REP_W-1:0]    r_surf_cnt [NUM_CH];
  logic [STRIDE_W-1:0] r_line_str [NUM_CH];
  logic [STRIDE_W-1:0] r_surf_str [NUM_CH];

  logic [CH_W-1:0]     r_rr;
  logic                r_vld;
  logic [AW-1:0]       r_addr;
  logic [LINE_W-1:0]   r_req_size;
  logic [CH_W-1:0]     r_ch;
  logic                r_last;
  logic [NUM_CH-1:0]   r_done;

  logic [NUM_CH-1:0]   w_sel;
  logic [NUM_CH-1:0]   w_idle;
  logic [NUM_CH-1:0]   w_active;
  logic                w_accept;
  logic                w_load;
  logic                w_hs;
  logic                w_gnt_vld;
  logic [CH_W-1:0]     w_gnt;
  logic [AW-1:0]       w_gnt_addr;
  logic [LINE_W-1:0]   w_gnt_size;
  logic                w_gnt_last;
  logic                w_unused_lsb;

  assign w_unused_lsb = ^cmd_src_addr[4:0];

  always_comb begin
    w_sel    = '0;
    w_idle   = '0;
    w_active = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sel[i]    = (cmd_ch == CH_W'(i));
      w_idle[i]   = (r_state[i] == ST_IDLE);
      w_active[i] = (r_state[i] == ST_ACTIVE);
    end
  end

  // An out-of-range cmd_ch selects no channel, so it is never accepted.
  assign cmd_ready = |(w_sel & w_idle);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_load    = !r_vld || rd_req_ready;
  assign w_hs      = r_vld && rd_req_ready;

  // Round-robin: first ACTIVE channel scanning rr+1, rr+2, ... modulo NUM_CH.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!w_gnt_vld && w_active[i] && (((int'(r_rr) + k) % NUM_CH) == i)) begin
          w_gnt_vld = 1'b1;
          w_gnt     = CH_W'(i);
        end
      end
    end
  end

  always_comb begin
    w_gnt_addr = '0;
    w_gnt_size = '0;
    w_gnt_last = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_gnt == CH_W'(i)) begin
        w_gnt_addr = r_line_ptr[i];
        w_gnt_size = r_size[i];
        w_gnt_last = (r_line_cnt[i] == r_line_rep[i]) && (r_surf_cnt[i] == r_surf_rep[i]);
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_vld      <= 1'b0;
      r_addr     <= '0;
      r_req_size <= '0;
      r_ch       <= '0;
      r_last     <= 1'b0;
      r_rr       <= CH_W'(NUM_CH - 1);
    end else if (w_load) begin
      r_vld <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_addr     <= w_gnt_addr;
        r_req_size <= w_gnt_size;
        r_ch       <= w_gnt;
        r_last     <= w_gnt_last;
        r_rr       <= w_gnt;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_done <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i]    <= ST_IDLE;
        r_line_ptr[i] <= '0;
        r_surf_ptr[i] <= '0;
        r_size[i]     <= '0;
        r_line_rep[i] <= '0;
        r_surf_rep[i] <= '0;
        r_line_cnt[i] <= '0;
        r_surf_cnt[i] <= '0;
        r_line_str[i] <= '0;
        r_surf_str[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_done[i] <= w_hs && r_last && (r_ch == CH_W'(i));
        case (r_state[i])
          ST_IDLE: begin
            if (w_accept && w_sel[i]) begin
              r_state[i]    <= ST_ACTIVE;
              r_line_ptr[i] <= {cmd_src_addr[AW-1:5], 5'b00000};
              r_surf_ptr[i] <= {cmd_src_addr[AW-1:5], 5'b00000};
              r_size[i]     <= cmd_line_size;
              r_line_rep[i] <= cmd_line_repeat;
              r_surf_rep[i] <= cmd_surf_repeat;
              r_line_cnt[i] <= '0;
              r_surf_cnt[i] <= '0;
              r_line_str[i] <= cmd_line_stride;
              r_surf_str[i] <= cmd_surf_stride;
            end
          end
          ST_ACTIVE: begin
            if (w_load && w_gnt_vld && (w_gnt == CH_W'(i))) begin
              if (r_line_cnt[i] < r_line_rep[i]) begin
                r_line_ptr[i] <= r_line_ptr[i] + AW'({r_line_str[i], 5'b00000});
                r_line_cnt[i] <= r_line_cnt[i] + REP_W'(1);
              end else if (r_surf_cnt[i] < r_surf_rep[i]) begin
                r_surf_ptr[i] <= r_surf_ptr[i] + AW'({r_surf_str[i], 5'b00000});
                r_line_ptr[i] <= r_surf_ptr[i] + AW'({r_surf_str[i], 5'b00000});
                r_line_cnt[i] <= '0;
                r_surf_cnt[i] <= r_surf_cnt[i] + REP_W'(1);
              end else begin
                r_state[i] <= ST_DRAIN;
              end
            end
          end
          ST_DRAIN: begin
            // The output register holds this channel's last request until it handshakes.
            if (w_hs && r_last && (r_ch == CH_W'(i))) begin
              r_state[i] <= ST_IDLE;
            end
          end
          default: r_state[i] <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef NVDLA_BDMA_MCH_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_stall_cnt <= '0;
    end else if (stall_cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (r_vld && !rd_req_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign rd_req_valid = r_vld;
  assign rd_req_addr  = r_addr;
  assign rd_req_size  = r_req_size;
  assign rd_req_ch    = r_ch;
  assign rd_req_last  = r_last;
  assign ch_busy      = ~w_idle;
  assign ch_done      = r_done;
  assign idle         = (&w_idle) && !r_vld;

endmodule

`default_nettype wire

// File: doc/nv_nvdla_bdma_mch_load.md
Name: nv_nvdla_bdma_mch_load

Overview:
Parametrised multi-channel successor to the single-context BDMA load engine. Holds NUM_CH independent copy descriptors and walks each one's line/surface loops. Arbitrates round-robin across active channels and issues one read request per line on a single valid/ready request port. Sits between the BDMA CSB/command front end and the MCIF/CVIF read-request mux; reports per-channel busy and done.

Parameters:
NUM_CH, 4, number of descriptor contexts (1..16)
CH_W, 2, channel index width, must be >= clog2(NUM_CH) and >= 1
AW, 64, byte address width
LINE_W, 13, line size field width (32B atoms minus 1)
REP_W, 24, line/surface repeat field width (count minus 1)
STRIDE_W, 27, stride width in 32B units

Ports:
nvdla_core_clk  in  1  clock
nvdla_core_rst  in  1  reset; asynchronous, active-high
cmd_valid  in  1  descriptor write valid
cmd_ready  out  1  descriptor accepted when high with cmd_valid
cmd_ch  in  CH_W  target channel
cmd_src_addr  in  AW  first line byte address (32B aligned; bits [4:0] ignored, forced 0)
cmd_line_size  in  LINE_W  atoms per line minus 1
cmd_line_repeat  in  REP_W  lines per surface minus 1
cmd_surf_repeat  in  REP_W  surfaces minus 1
cmd_line_stride  in  STRIDE_W  line stride, 32B units
cmd_surf_stride  in  STRIDE_W  surface stride, 32B units
rd_req_valid  out  1  read request valid
rd_req_ready  in  1  read request accepted
rd_req_addr  out  AW  request byte address
rd_req_size  out  LINE_W  atoms minus 1
rd_req_ch  out  CH_W  owning channel
rd_req_last  out  1  final request of the channel's descriptor
ch_busy  out  NUM_CH  channel not IDLE
ch_done  out  NUM_CH  one-cycle completion pulse per channel
idle  out  1  all channels IDLE and rd_req_valid low

Behaviour:
- Reset: all contexts IDLE, all outputs 0, rr pointer = NUM_CH-1 (channel 0 wins first).
- Per-channel FSM: IDLE -> ACTIVE on accepted cmd; ACTIVE -> DRAIN when its last request loads into the output register; DRAIN -> IDLE on handshake of that request.
- cmd_ready = (cmd_ch < NUM_CH) && channel cmd_ch IDLE; combinational. cmd_ch >= NUM_CH: cmd_ready=0, stalls forever (illegal).
- Accept latches descriptor; line_ptr = surf_ptr = src_addr; line_cnt = surf_cnt = 0; ch_busy bit set next cycle.
- Output register: loads when rd_req_valid=0 or rd_req_ready=1 (same-cycle refill), so back-to-back issue at 1 req/cycle with ready held high. Payload held stable while valid && !ready.
- Arbitration: among ACTIVE channels only, first found scanning rr+1, rr+2, ... mod NUM_CH; rr <= granted channel on load. A channel accepted this cycle is not eligible until next cycle.
- Issue from channel g: addr = line_ptr; last = (line_cnt==line_repeat && surf_cnt==surf_repeat).
- Update: line_cnt<line_repeat -> line_ptr += line_stride<<5, line_cnt++; else surf_cnt<surf_repeat -> surf_ptr += surf_stride<<5, line_ptr = new surf_ptr, line_cnt=0, surf_cnt++; else -> DRAIN.
- Address sums wrap modulo 2^AW, no error.
- ch_done[g] registered: pulses the cycle after the last request's handshake; ch_busy[g] clears that same cycle. Channel re-acceptable from then.
- Reset mid-operation: contexts and output register cleared immediately; no done pulses.

Optional Feature:
Macro NVDLA_BDMA_MCH_STALL_CNT_EN. When defined, add ports stall_cnt_clr (in, 1) and stall_cnt (out, 32). The 32-bit counter increments each cycle rd_req_valid && !rd_req_ready, saturates at 0xFFFFFFFF, and is cleared synchronously by stall_cnt_clr; clear wins over increment; reset value 0. When undefined, neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Single channel: ch0, addr 0x1000, size 3, line_repeat 2, surf_repeat 1, line_stride 4, surf_stride 16, ready=1 -> 6 requests at 0x1000, 0x1080, 0x1100, 0x1200, 0x1280, 0x1300, all size 3; last set only on 0x1300; ch_done[0] pulses 1 cycle after that handshake.
- Round-robin: ch0..ch3 each programmed with 2 lines, ready=1 -> rd_req_ch sequence 0,1,2,3,0,1,2,3; each channel's ch_done in order 0,1,2,3.
- Backpressure: ready=0 for 5 cycles mid-stream -> addr/size/ch/last stable; no request dropped or duplicated; with macro on, stall_cnt=5.
- Busy reject: reprogram ch1 while ACTIVE -> cmd_ready=0 until cycle ch_done[1] pulses, then accepted.
- Wrap: AW=64, addr 0xFFFF_FFFF_FFFF_FFE0, line_repeat 1, line_stride 1 -> second request addr 0x0.
- Async reset asserted mid-descriptor -> rd_req_valid, ch_busy, ch_done all 0 immediately; idle=1 after release.
